// File: rtl/voice_allocator_if.sv
// Event and voice-bank bus between the MIDI decoder, the voice allocator
// and the synth voices.
interface voice_allocator_if #(
  parameter int NUM_VOICES = 8
);
  logic                      note_event_ready;
  logic                      note_on;
  logic [6:0]                note;
  logic [6:0]                velocity;
  logic                      busy;
  logic                      dropped;
  logic [NUM_VOICES-1:0]     voice_active;
  logic [7*NUM_VOICES-1:0]   voice_note;
  logic [7*NUM_VOICES-1:0]   voice_velocity;
  logic [NUM_VOICES-1:0]     voice_trigger;
  logic [NUM_VOICES-1:0]     voice_release;

  modport master (
    output note_event_ready, note_on, note, velocity,
    input  busy, dropped, voice_active, voice_note, voice_velocity,
           voice_trigger, voice_release
  );

  modport slave (
    input  note_event_ready, note_on, note, velocity,
    output busy, dropped, voice_active, voice_note, voice_velocity,
           voice_trigger, voice_release
  );
endinterface

// File: rtl/voice_allocator.sv
// Polyphony scheduler: maps note-on/off events onto NUM_VOICES slots with
// retrigger reuse, first-free allocation and round-robin stealing.
module voice_allocator #(
  parameter int NUM_VOICES = 8
) (
  input  logic              clk,
  input  logic              reset,
  voice_allocator_if.slave  bus
);
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  logic [1:0]            r_state;
  logic                  r_on;
  logic [6:0]            r_note;
  logic [6:0]            r_vel;
  logic [IDX_W-1:0]      r_scan_idx;
  logic                  r_match_found;
  logic [IDX_W-1:0]      r_match_idx;
  logic                  r_free_found;
  logic [IDX_W-1:0]      r_free_idx;
  logic [IDX_W-1:0]      r_steal_ptr;
  logic                  r_dropped;
  logic [NUM_VOICES-1:0] r_active;
  logic [NUM_VOICES-1:0] r_trig;
  logic [NUM_VOICES-1:0] r_rel;
  logic [6:0]            r_notes [NUM_VOICES];
  logic [6:0]            r_vels  [NUM_VOICES];

  logic                  w_scan_match;
  logic                  w_scan_free;
  logic [7*NUM_VOICES-1:0] w_note_flat;
  logic [7*NUM_VOICES-1:0] w_vel_flat;

  assign w_scan_match = r_active[r_scan_idx] && (r_notes[r_scan_idx] == r_note);
  assign w_scan_free  = !r_active[r_scan_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_on          <= 1'b0;
      r_note        <= '0;
      r_vel         <= '0;
      r_scan_idx    <= '0;
      r_match_found <= 1'b0;
      r_match_idx   <= '0;
      r_free_found  <= 1'b0;
      r_free_idx    <= '0;
      r_steal_ptr   <= '0;
      r_dropped     <= 1'b0;
      r_active      <= '0;
      r_trig        <= '0;
      r_rel         <= '0;
      // NOTE: the per-voice note/velocity registers are cleared too; they are
      // flops, not RAM, and downstream voices read them directly after reset.
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_notes[i] <= '0;
        r_vels[i]  <= '0;
      end
    end else begin
      // NOTE: non-blocking throughout so every branch sees start-of-cycle state.
      r_trig <= '0;
      r_rel  <= '0;
      if (bus.note_event_ready && (r_state != ST_IDLE))
        r_dropped <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (bus.note_event_ready) begin
            // Zero velocity note-on is a note-off in MIDI running-status usage.
            r_on          <= bus.note_on && (bus.velocity != 7'd0);
            r_note        <= bus.note;
            r_vel         <= bus.velocity;
            r_scan_idx    <= '0;
            r_match_found <= 1'b0;
            r_free_found  <= 1'b0;
            r_state       <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (!r_match_found && w_scan_match) begin
            r_match_found <= 1'b1;
            r_match_idx   <= r_scan_idx;
          end
          if (!r_free_found && w_scan_free) begin
            r_free_found <= 1'b1;
            r_free_idx   <= r_scan_idx;
          end
          if (r_scan_idx == LAST_IDX) r_state <= ST_COMMIT;
          else                        r_scan_idx <= r_scan_idx + 1'b1;
        end

        ST_COMMIT: begin
          if (r_on) begin
            if (r_match_found) begin
              r_vels[r_match_idx] <= r_vel;
              r_trig[r_match_idx] <= 1'b1;
            end else if (r_free_found) begin
              r_notes[r_free_idx]  <= r_note;
              r_vels[r_free_idx]   <= r_vel;
              r_active[r_free_idx] <= 1'b1;
              r_trig[r_free_idx]   <= 1'b1;
            end else begin
              // Stolen voice retriggers without a release pulse.
              r_notes[r_steal_ptr] <= r_note;
              r_vels[r_steal_ptr]  <= r_vel;
              r_trig[r_steal_ptr]  <= 1'b1;
              r_steal_ptr <= (r_steal_ptr == LAST_IDX) ? '0 : r_steal_ptr + 1'b1;
            end
          end else if (r_match_found) begin
            r_active[r_match_idx] <= 1'b0;
            r_rel[r_match_idx]    <= 1'b1;
          end
          r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_note_flat = '0;
    w_vel_flat  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_note_flat[7*i +: 7] = r_notes[i];
      w_vel_flat[7*i +: 7]  = r_vels[i];
    end
  end

  assign bus.busy           = (r_state != ST_IDLE);
  assign bus.dropped        = r_dropped;
  assign bus.voice_active   = r_active;
  assign bus.voice_note     = w_note_flat;
  assign bus.voice_velocity = w_vel_flat;
  assign bus.voice_trigger  = r_trig;
  assign bus.voice_release  = r_rel;
endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: a behavioural allocation model queues
// the expected voice-bank state for each event, compared at the output cycle.
module tb_voice_allocator;
  localparam int N = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  voice_allocator_if #(.NUM_VOICES(N)) bus ();
  voice_allocator #(.NUM_VOICES(N)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  typedef struct {
    logic [N-1:0]   active;
    logic [N-1:0]   trig;
    logic [N-1:0]   rel;
    logic [7*N-1:0] notes;
    logic [7*N-1:0] vels;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic       m_active [N];
  logic [6:0] m_note   [N];
  logic [6:0] m_vel    [N];
  int         m_steal;
  logic       m_dropped;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_active[i] = 1'b0;
      m_note[i]   = '0;
      m_vel[i]    = '0;
    end
    m_steal   = 0;
    m_dropped = 1'b0;
    exp_q.delete();
  endtask

  task automatic push_expected(input bit on, input logic [6:0] nt, input logic [6:0] vl);
    exp_t e;
    int   match = -1;
    int   free  = -1;
    bit   eff_on = on && (vl != 7'd0);
    e.trig = '0;
    e.rel  = '0;
    for (int i = 0; i < N; i++) begin
      if (match < 0 && m_active[i] && m_note[i] == nt) match = i;
      if (free < 0 && !m_active[i]) free = i;
    end
    if (eff_on) begin
      if (match >= 0) begin
        m_vel[match] = vl;
        e.trig[match] = 1'b1;
      end else if (free >= 0) begin
        m_note[free] = nt; m_vel[free] = vl; m_active[free] = 1'b1;
        e.trig[free] = 1'b1;
      end else begin
        m_note[m_steal] = nt; m_vel[m_steal] = vl;
        e.trig[m_steal] = 1'b1;
        m_steal = (m_steal + 1) % N;
      end
    end else if (match >= 0) begin
      m_active[match] = 1'b0;
      e.rel[match] = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      e.active[i]       = m_active[i];
      e.notes[7*i +: 7] = m_note[i];
      e.vels[7*i +: 7]  = m_vel[i];
    end
    exp_q.push_back(e);
  endtask

  // Drives one event at cycle E; optionally a second strobe at E+drop_at
  // while busy. Returns in cycle E+N+2 with the result on the outputs.
  task automatic do_event(input bit on, input logic [6:0] nt, input logic [6:0] vl,
                          input int drop_at);
    exp_t e;
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL idle_before_event: busy=%b want 0", bus.busy);
    end
    bus.note_event_ready = 1'b1;
    bus.note_on  = on;
    bus.note     = nt;
    bus.velocity = vl;
    push_expected(on, nt, vl);
    if (drop_at > 0) m_dropped = 1'b1;
    for (int c = 1; c <= N + 1; c++) begin
      step();
      bus.note_event_ready = (c == drop_at);
      if (c == 1) begin
        n_cmp++;
        if (bus.voice_trigger !== '0 || bus.voice_release !== '0) begin
          n_err++;
          $display("FAIL pulse_width: trig=%h rel=%h want 0", bus.voice_trigger, bus.voice_release);
        end
      end
      n_cmp++;
      if (bus.busy !== 1'b1) begin
        n_err++; $display("FAIL busy_window E+%0d: busy=%b want 1", c, bus.busy);
      end
    end
    step();
    bus.note_event_ready = 1'b0;
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++; $display("FAIL scoreboard_empty: no expected entry");
    end else begin
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.voice_active !== e.active) begin
        n_err++; $display("FAIL active note=%0d: got %h want %h", nt, bus.voice_active, e.active);
      end
      n_cmp++;
      if (bus.voice_trigger !== e.trig) begin
        n_err++; $display("FAIL trigger note=%0d: got %h want %h", nt, bus.voice_trigger, e.trig);
      end
      n_cmp++;
      if (bus.voice_release !== e.rel) begin
        n_err++; $display("FAIL release note=%0d: got %h want %h", nt, bus.voice_release, e.rel);
      end
      n_cmp++;
      if (bus.voice_note !== e.notes) begin
        n_err++; $display("FAIL notes note=%0d: got %h want %h", nt, bus.voice_note, e.notes);
      end
      n_cmp++;
      if (bus.voice_velocity !== e.vels) begin
        n_err++; $display("FAIL vels note=%0d: got %h want %h", nt, bus.voice_velocity, e.vels);
      end
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL busy_after_commit: busy=%b want 0", bus.busy);
    end
    n_cmp++;
    if (bus.dropped !== m_dropped) begin
      n_err++; $display("FAIL dropped: got %b want %b", bus.dropped, m_dropped);
    end
  endtask

  task automatic check_quiet(input string tag);
    step();
    n_cmp++;
    if (bus.voice_trigger !== '0 || bus.voice_release !== '0) begin
      n_err++;
      $display("FAIL %s_pulse_end: trig=%h rel=%h want 0", tag, bus.voice_trigger, bus.voice_release);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_state(input string tag);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.dropped !== 1'b0 || bus.voice_active !== '0 ||
        bus.voice_trigger !== '0 || bus.voice_release !== '0 ||
        bus.voice_note !== '0 || bus.voice_velocity !== '0) begin
      n_err++;
      $display("FAIL %s: busy=%b drop=%b act=%h trig=%h rel=%h notes=%h vels=%h want all 0",
               tag, bus.busy, bus.dropped, bus.voice_active, bus.voice_trigger,
               bus.voice_release, bus.voice_note, bus.voice_velocity);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    check_reset_state("reset_state");
  endtask

  task automatic test_first_note();
    apply_reset();
    do_event(1'b1, 7'd60, 7'd100, 0);
    n_cmp++;
    if (bus.voice_active !== 8'h01 || bus.voice_trigger !== 8'h01 ||
        bus.voice_note[6:0] !== 7'd60 || bus.voice_velocity[6:0] !== 7'd100) begin
      n_err++;
      $display("FAIL first_note: act=%h trig=%h n0=%0d v0=%0d want 01 01 60 100",
               bus.voice_active, bus.voice_trigger, bus.voice_note[6:0], bus.voice_velocity[6:0]);
    end
    check_quiet("first_note");
  endtask

  task automatic test_retrigger();
    apply_reset();
    do_event(1'b1, 7'd60, 7'd100, 0);
    do_event(1'b1, 7'd60, 7'd40, 0);
    n_cmp++;
    if (bus.voice_active !== 8'h01 || bus.voice_trigger !== 8'h01 || bus.voice_velocity[6:0] !== 7'd40) begin
      n_err++;
      $display("FAIL retrigger: act=%h trig=%h v0=%0d want 01 01 40",
               bus.voice_active, bus.voice_trigger, bus.voice_velocity[6:0]);
    end
    check_quiet("retrigger");
  endtask

  task automatic test_release();
    apply_reset();
    do_event(1'b1, 7'd60, 7'd90, 0);
    do_event(1'b1, 7'd64, 7'd80, 0);
    do_event(1'b0, 7'd60, 7'd0, 0);
    n_cmp++;
    if (bus.voice_release !== 8'h01 || bus.voice_active !== 8'h02 || bus.voice_note[6:0] !== 7'd60) begin
      n_err++;
      $display("FAIL release: rel=%h act=%h n0=%0d want 01 02 60",
               bus.voice_release, bus.voice_active, bus.voice_note[6:0]);
    end
    do_event(1'b0, 7'd72, 7'd64, 0);
    check_quiet("release");
  endtask

  task automatic test_back_to_back_steal();
    apply_reset();
    for (int k = 0; k < 9; k++)
      do_event(1'b1, 7'(60 + k), 7'(20 + k), 0);
    n_cmp++;
    if (bus.voice_note[6:0] !== 7'd68 || bus.voice_trigger !== 8'h01 ||
        bus.voice_release !== 8'h00 || dut.r_steal_ptr !== 3'd1) begin
      n_err++;
      $display("FAIL steal_first: n0=%0d trig=%h rel=%h ptr=%0d want 68 01 00 1",
               bus.voice_note[6:0], bus.voice_trigger, bus.voice_release, dut.r_steal_ptr);
    end
    do_event(1'b1, 7'd69, 7'd50, 0);
    n_cmp++;
    if (bus.voice_note[13:7] !== 7'd69 || bus.voice_trigger !== 8'h02 || dut.r_steal_ptr !== 3'd2) begin
      n_err++;
      $display("FAIL steal_second: n1=%0d trig=%h ptr=%0d want 69 02 2",
               bus.voice_note[13:7], bus.voice_trigger, dut.r_steal_ptr);
    end
    check_quiet("steal");
  endtask

  task automatic test_vel_zero_off();
    apply_reset();
    do_event(1'b1, 7'd60, 7'd100, 0);
    do_event(1'b1, 7'd60, 7'd0, 0);
    n_cmp++;
    if (bus.voice_release !== 8'h01 || bus.voice_active !== 8'h00 || bus.voice_trigger !== 8'h00) begin
      n_err++;
      $display("FAIL vel_zero: rel=%h act=%h trig=%h want 01 00 00",
               bus.voice_release, bus.voice_active, bus.voice_trigger);
    end
    check_quiet("vel_zero");
  endtask

  task automatic test_drop_and_abort();
    apply_reset();
    do_event(1'b1, 7'd50, 7'd70, 3);
    step();
    n_cmp++;
    if (bus.dropped !== 1'b1) begin
      n_err++; $display("FAIL dropped_sticky: got %b want 1", bus.dropped);
    end
    // Abort an event mid-SCAN with reset; no trigger may follow.
    bus.note_event_ready = 1'b1;
    bus.note_on  = 1'b1;
    bus.note     = 7'd77;
    bus.velocity = 7'd33;
    step();
    bus.note_event_ready = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    check_reset_state("abort_reset");
    for (int c = 0; c < N + 3; c++) begin
      step();
      n_cmp++;
      if (bus.voice_trigger !== '0 || bus.voice_active !== '0 || bus.busy !== 1'b0) begin
        n_err++;
        $display("FAIL abort_no_pulse c=%0d: trig=%h act=%h busy=%b want 0 0 0",
                 c, bus.voice_trigger, bus.voice_active, bus.busy);
      end
    end
    do_event(1'b1, 7'd65, 7'd10, 0);
    check_quiet("after_abort");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.note_event_ready = 1'b0;
    bus.note_on  = 1'b0;
    bus.note     = '0;
    bus.velocity = '0;
    model_reset();
    test_reset();
    test_first_note();
    test_retrigger();
    test_release();
    test_back_to_back_steal();
    test_vel_zero_off();
    test_drop_and_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphony scheduler between the MIDI decoder and the synth voice bank. It accepts decoded note-on/note-off events and assigns each note to one of `NUM_VOICES` voice slots. Voices are reused on retrigger, a free voice is taken when one exists, and a voice is stolen round-robin when all are busy. Per-voice note/velocity registers plus one-cycle trigger/release pulses drive the oscillator/envelope voices downstream.

## Interface
- `NUM_VOICES`, default 8: number of voice slots; must be 2..16.
- `clk` input 1: system clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high; clears all state.
- `note_event_ready` input 1: one-cycle strobe from decoder; event valid this cycle.
- `note_on` input 1: 1 = note-on, 0 = note-off.
- `note` input 7: MIDI note number.
- `velocity` input 7: MIDI velocity.
- `busy` output 1: allocator processing an event; strobes ignored while high.
- `dropped` output 1: sticky; set when a strobe arrives while `busy`; cleared only by reset.
- `voice_active` output NUM_VOICES: bit i = voice i holds a sounding note.
- `voice_note` output 7*NUM_VOICES: voice i note at bits [7i+6:7i].
- `voice_velocity` output 7*NUM_VOICES: voice i velocity, same packing.
- `voice_trigger` output NUM_VOICES: one-cycle pulse; voice i (re)started.
- `voice_release` output NUM_VOICES: one-cycle pulse; voice i released.

## Operation
- FSM states: IDLE, SCAN, COMMIT.
- IDLE: `busy`=0. On `note_event_ready`, capture `note_on`, `note`, `velocity`; clear scan index, match/free found flags; go to SCAN.
- Note-on with `velocity`==0 is captured as note-off.
- SCAN: examines voice `scan_idx` per cycle, 0..NUM_VOICES-1 ascending.
  - Match: first voice with `voice_active` and `voice_note`==captured note; record index.
  - Free: first voice with `voice_active`==0; record index.
  - After voice NUM_VOICES-1, go to COMMIT.
- COMMIT: apply the decision, then go to IDLE.
  - Note-on with match: update that voice's velocity and pulse its `voice_trigger`. Active stays 1.
  - Note-on, no match, free found: load note/velocity into the free voice, set active, pulse trigger.
  - Note-on, no match, no free voice: steal voice `steal_ptr`. Load note/velocity and pulse trigger; do not pulse `voice_release`. Then `steal_ptr` increments, wrapping NUM_VOICES-1→0.
  - Note-off with match: clear active, pulse `voice_release`. Note/velocity registers keep their values.
  - Note-off without match: no change, no pulses.
- Only one voice changes per event. All other voices hold.
- `steal_ptr` width is clog2(NUM_VOICES). It advances only on a steal.
- Reset values:
  - State IDLE; `busy` 0; `dropped` 0.
  - All `voice_active`, `voice_trigger`, `voice_release` 0.
  - All `voice_note`, `voice_velocity` 0; `steal_ptr` 0.
- Reset mid-SCAN/COMMIT aborts the event with no voice update and no pulse. Next cycle is IDLE.

## Timing
- Strobe accepted in IDLE at cycle E.
- `busy` is decoded from state: 0 at E, 1 at E+1..E+NUM_VOICES+1 (SCAN, then COMMIT).
- SCAN occupies E+1..E+NUM_VOICES. COMMIT is at E+NUM_VOICES+1.
- Voice registers and trigger/release pulses are visible at E+NUM_VOICES+2. Pulses last exactly one cycle.
- A new strobe is accepted at E+NUM_VOICES+2 at the earliest. Back-to-back throughput is one event per NUM_VOICES+2 cycles.
- A strobe with `busy`=1 is discarded. `dropped` goes to 1 the following cycle.
- Latency is identical for every outcome, including an ignored note-off.

## Test plan
- Reset, then note-on 60 vel 100 at E → at E+10 (N=8): `voice_active`=0x01, voice0 note 60 vel 100, `voice_trigger`=0x01 for one cycle.
- Note-on 60 vel 100, then note-on 60 vel 40 → still voice0 only; vel becomes 40; second trigger on voice0; `voice_active`=0x01.
- Note-on 60, note-on 64, note-off 60 → `voice_release`=0x01 pulse, `voice_active`=0x02. A following note-off 72 changes nothing.
- Nine distinct note-ons 60..68 (N=8) → 68 steals voice0, 60 is overwritten, `steal_ptr`=1. A tenth note-on 69 steals voice1.
- Note-on 60 vel 0 after note-on 60 → treated as off: release pulse on voice0, active cleared.
- Strobe at E+3 during busy → ignored, `dropped`=1 stays set. Assert `reset` mid-SCAN → all outputs return to reset values; no trigger pulse appears.
